// File: rtl/mdu_sequencer_pkg.sv
// Shared MDU op/select codes, FSM state encoding and op classification helpers.
package mdu_sequencer_pkg;

  localparam logic [2:0] MULDIV_DO_MUL    = 3'd0;
  localparam logic [2:0] MULDIV_DO_MULU   = 3'd1;
  localparam logic [2:0] MULDIV_DO_DIV    = 3'd2;
  localparam logic [2:0] MULDIV_DO_DIVU   = 3'd3;
  localparam logic [2:0] MULDIV_SELECT_HI = 3'd4;
  localparam logic [2:0] MULDIV_SELECT_LO = 3'd5;
  localparam logic [2:0] MULDIV_NONE      = 3'd7;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  function automatic logic is_arith_op(input logic [2:0] sel);
    return (sel == MULDIV_DO_MUL) || (sel == MULDIV_DO_MULU) ||
           (sel == MULDIV_DO_DIV) || (sel == MULDIV_DO_DIVU);
  endfunction

  function automatic logic is_mul_op(input logic [2:0] sel);
    return (sel == MULDIV_DO_MUL) || (sel == MULDIV_DO_MULU);
  endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// E-stage MDU request/response bundle between the pipeline (master) and the sequencer (slave).
interface mdu_sequencer_if;
  logic        start;
  logic        move_to;
  logic [2:0]  sel;
  logic        cancel;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, move_to, sel, cancel, rs_val, rt_val,
    input  busy, rd_data, hi, lo
  );

  modport slave (
    input  start, move_to, sel, cancel, rs_val, rt_val,
    output busy, rd_data, hi, lo
  );
endinterface

// File: rtl/mdu_sequencer_arith.sv
// Combinational MDU datapath: {hi,lo} for mult/multu/div/divu plus divide-by-zero flag.
module mdu_sequencer_arith
  import mdu_sequencer_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic [31:0] a_mag, b_mag, b_mag_safe, b_safe;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

  // Signed divide via magnitudes so 0x80000000 / -1 yields 0x80000000 with no overflow trap.
  assign a_mag      = a[31] ? -a : a;
  assign b_mag      = b[31] ? -b : b;
  assign b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign b_safe     = (b == 32'd0) ? 32'd1 : b;
  assign q_mag      = a_mag / b_mag_safe;
  assign r_mag      = a_mag % b_mag_safe;
  assign q_s        = (a[31] ^ b[31]) ? -q_mag : q_mag;
  assign r_s        = a[31] ? -r_mag : r_mag;
  assign q_u        = a / b_safe;
  assign r_u        = a % b_safe;

  always_comb begin
    result      = 64'd0;
    div_by_zero = 1'b0;
    case (op)
      MULDIV_DO_MUL:  result = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      MULDIV_DO_MULU: result = {32'd0, a} * {32'd0, b};
      MULDIV_DO_DIV: begin
        result      = {r_s, q_s};
        div_by_zero = (b == 32'd0);
      end
      MULDIV_DO_DIVU: begin
        result      = {r_u, q_u};
        div_by_zero = (b == 32'd0);
      end
      default: result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// MDU controller: fixed-latency mult/div sequencing, HI/LO ownership and busy for the hazard unit.
//  state    | meaning
//  MDU_IDLE | accepts start / move_to; HI/LO stable
//  MDU_BUSY | op in flight; count runs down, commit when count==1
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic            clk,
  input  logic            reset,
  mdu_sequencer_if.slave  mdu
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic              pend_dbz_q, pend_dbz_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [63:0]       arith_res;
  logic              arith_dbz;

  mdu_sequencer_arith u_arith (
    .op          (mdu.sel),
    .a           (mdu.rs_val),
    .b           (mdu.rt_val),
    .result      (arith_res),
    .div_by_zero (arith_dbz)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= MDU_IDLE;
      count_q    <= '0;
      pend_hi_q  <= '0;
      pend_lo_q  <= '0;
      pend_dbz_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      pend_hi_q  <= pend_hi_d;
      pend_lo_q  <= pend_lo_d;
      pend_dbz_q <= pend_dbz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    pend_hi_d  = pend_hi_q;
    pend_lo_d  = pend_lo_q;
    pend_dbz_d = pend_dbz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      MDU_IDLE: begin
        // start takes priority over move_to even when its sel is not an arith op
        if (mdu.start) begin
          if (!mdu.cancel && is_arith_op(mdu.sel)) begin
            state_d    = MDU_BUSY;
            count_d    = is_mul_op(mdu.sel) ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
            pend_hi_d  = arith_res[63:32];
            pend_lo_d  = arith_res[31:0];
            pend_dbz_d = arith_dbz;
          end
        end else if (mdu.move_to && !mdu.cancel) begin
          if (mdu.sel == MULDIV_SELECT_HI) hi_d = mdu.rs_val;
          else if (mdu.sel == MULDIV_SELECT_LO) lo_d = mdu.rs_val;
        end
      end
      MDU_BUSY: begin
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d = MDU_IDLE;
          if (!pend_dbz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  assign mdu.busy    = (state_q == MDU_BUSY);
  assign mdu.hi      = hi_q;
  assign mdu.lo      = lo_q;
  assign mdu.rd_data = (mdu.sel == MULDIV_SELECT_HI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: stimulus queues expected {hi,lo,busy length}, monitor checks on busy fall.
module tb_mdu_sequencer;
  import mdu_sequencer_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  mdu_sequencer_if mif();

  mdu_sequencer #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    mif.start = 1'b1; mif.sel = op; mif.rs_val = a; mif.rt_val = b;
    @(posedge clk); #1;
    mif.start = 1'b0; mif.sel = MULDIV_NONE;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 64; i++) begin
      if (mif.busy !== 1'b1) break;
      @(posedge clk); #1;
    end
    chk({nm, "_idle"}, {31'd0, mif.busy}, 32'd0);
  endtask

  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int len);
    exp_q.push_back('{nm, ehi, elo, len});
    issue(op, a, b);
    wait_idle(nm);
  endtask

  task automatic move(input logic [2:0] which, input logic [31:0] v, input logic cxl);
    @(posedge clk); #1;
    mif.move_to = 1'b1; mif.sel = which; mif.rs_val = v; mif.cancel = cxl;
    @(posedge clk); #1;
    mif.move_to = 1'b0; mif.cancel = 1'b0; mif.sel = MULDIV_NONE;
  endtask

  // Monitor: a busy high->low transition completes one op; compare against the oldest expectation.
  initial begin : monitor
    int   len;
    logic prev;
    exp_t e;
    len  = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mif.busy === 1'b1) len++;
      else begin
        if (prev) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_op actual_len=%0d required=none", len);
          end else begin
            e = exp_q.pop_front();
            chk({e.name, "_hi"}, mif.hi, e.hi);
            chk({e.name, "_lo"}, mif.lo, e.lo);
            chk({e.name, "_len"}, len, e.len);
          end
        end
        len = 0;
      end
      prev = (mif.busy === 1'b1);
    end
  end

  initial begin : watchdog
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    mif.start = 1'b0; mif.move_to = 1'b0; mif.cancel = 1'b0;
    mif.sel = MULDIV_NONE; mif.rs_val = '0; mif.rt_val = '0;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, mif.busy}, 32'd0);
    chk("rst_hi", mif.hi, 32'd0);
    chk("rst_lo", mif.lo, 32'd0);
    chk("rst_rd", mif.rd_data, 32'd0);
    reset = 1'b1;

    // mult -2*3, with reads during busy returning pre-op HI
    exp_q.push_back('{"mult_neg", 32'hFFFFFFFF, 32'hFFFFFFFA, 5});
    issue(MULDIV_DO_MUL, 32'hFFFFFFFE, 32'd3);
    mif.sel = MULDIV_SELECT_HI; #1;
    chk("busy_rd_hi", mif.rd_data, 32'd0);
    chk("busy_flag", {31'd0, mif.busy}, 32'd1);
    mif.sel = MULDIV_NONE;
    wait_idle("mult_neg");

    run_op("multu_max", MULDIV_DO_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
    run_op("mult_big", MULDIV_DO_MUL, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5);
    run_op("mult_min", MULDIV_DO_MUL, 32'h80000000, 32'd1, 32'hFFFFFFFF, 32'h80000000, 5);
    run_op("multu_min", MULDIV_DO_MULU, 32'h80000000, 32'd2, 32'h00000001, 32'h00000000, 5);
    run_op("div_neg", MULDIV_DO_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    run_op("div_negdiv", MULDIV_DO_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10);
    run_op("divu_small", MULDIV_DO_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    run_op("divu_big", MULDIV_DO_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 32'h0FFFFFFF, 10);
    run_op("div_ovf", MULDIV_DO_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);

    // move-to and mf reads
    move(MULDIV_SELECT_HI, 32'h12345678, 1'b0);
    chk("mthi_hi", mif.hi, 32'h12345678);
    chk("mthi_busy", {31'd0, mif.busy}, 32'd0);
    mif.sel = MULDIV_SELECT_HI; #1;
    chk("mfhi_rd", mif.rd_data, 32'h12345678);
    mif.sel = MULDIV_SELECT_LO; #1;
    chk("mflo_rd", mif.rd_data, 32'h80000000);
    mif.sel = MULDIV_NONE;
    move(MULDIV_SELECT_LO, 32'hCAFEF00D, 1'b0);
    chk("mtlo_lo", mif.lo, 32'hCAFEF00D);
    move(MULDIV_SELECT_HI, 32'hDEADBEEF, 1'b1);
    chk("mthi_cancel", mif.hi, 32'h12345678);

    run_op("divu_zero", MULDIV_DO_DIVU, 32'd55, 32'd0, 32'h12345678, 32'hCAFEF00D, 10);
    run_op("div_zero", MULDIV_DO_DIV, 32'hFFFFFF00, 32'd0, 32'h12345678, 32'hCAFEF00D, 10);

    // cancelled start and non-arith start are both dropped
    @(posedge clk); #1;
    mif.start = 1'b1; mif.cancel = 1'b1; mif.sel = MULDIV_DO_MUL;
    mif.rs_val = 32'd5; mif.rt_val = 32'd5;
    @(posedge clk); #1;
    mif.start = 1'b0; mif.cancel = 1'b0; mif.sel = MULDIV_NONE;
    chk("cancel_busy", {31'd0, mif.busy}, 32'd0);
    @(posedge clk); #1;
    chk("cancel_hi", mif.hi, 32'h12345678);
    chk("cancel_lo", mif.lo, 32'hCAFEF00D);
    issue(MULDIV_SELECT_HI, 32'd9, 32'd9);
    chk("badsel_busy", {31'd0, mif.busy}, 32'd0);
    chk("badsel_hi", mif.hi, 32'h12345678);

    // start during busy is ignored
    exp_q.push_back('{"mult_keep", 32'd0, 32'd6, 5});
    issue(MULDIV_DO_MUL, 32'd2, 32'd3);
    @(posedge clk); #1;
    mif.start = 1'b1; mif.sel = MULDIV_DO_DIV; mif.rs_val = 32'd100; mif.rt_val = 32'd7;
    @(posedge clk); #1;
    mif.start = 1'b0; mif.sel = MULDIV_NONE;
    wait_idle("mult_keep");
    @(posedge clk); #1;
    chk("after_keep_busy", {31'd0, mif.busy}, 32'd0);

    // reset during busy cycle 3 of a div aborts it
    exp_q.push_back('{"rst_abort", 32'd0, 32'd0, 2});
    issue(MULDIV_DO_DIV, 32'd100, 32'd7);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0; #1;
    chk("midrst_busy", {31'd0, mif.busy}, 32'd0);
    chk("midrst_hi", mif.hi, 32'd0);
    chk("midrst_lo", mif.lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    run_op("mult_post", MULDIV_DO_MUL, 32'd3, 32'd4, 32'd0, 32'd12, 5);

    repeat (3) @(posedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
